// File: rtl/pipeline_debug_ctrl_if.sv
// Debug link between the pipeline debug controller and the rest of the
// MIPS core: command port, halt/stop pair, register file debug read port
// and the valid/ready dump stream toward the UART framer.
interface pipeline_debug_ctrl_if #(
    parameter int NB_DATA  = 32,
    parameter int NB_ADDR  = 5,
    parameter int NB_CYCLE = 32
);
    logic                i_cmd_valid;
    logic [1:0]          i_cmd;
    logic                o_cmd_ready;
    logic                i_stop;
    logic                o_halt;
    logic                o_done;
    logic [NB_ADDR-1:0]  o_rf_dbg_addr;
    logic [NB_DATA-1:0]  i_rf_dbg_data;
    logic                o_dump_valid;
    logic [NB_DATA-1:0]  o_dump_data;
    logic                o_dump_last;
    logic                i_dump_ready;
    logic [NB_CYCLE-1:0] o_cycle_count;

    // Controller side
    modport master (
        input  i_cmd_valid, i_cmd, i_stop, i_rf_dbg_data, i_dump_ready,
        output o_cmd_ready, o_halt, o_done, o_rf_dbg_addr,
               o_dump_valid, o_dump_data, o_dump_last, o_cycle_count
    );

    // Pipeline / host side
    modport slave (
        output i_cmd_valid, i_cmd, i_stop, i_rf_dbg_data, i_dump_ready,
        input  o_cmd_ready, o_halt, o_done, o_rf_dbg_addr,
               o_dump_valid, o_dump_data, o_dump_last, o_cycle_count
    );
endinterface

// File: rtl/pipeline_debug_ctrl.sv
// Pipeline debug controller: run-to-halt, single-step and register dump.
// Owns the global pipeline halt, counts un-halted cycles and streams every
// register followed by the cycle count over a valid/ready link.
module pipeline_debug_ctrl #(
    parameter int NB_DATA  = 32,
    parameter int NB_ADDR  = 5,
    parameter int NB_REGS  = 32,
    parameter int NB_CYCLE = 32
) (
    input  logic                  clk,
    input  logic                  i_rst,
    pipeline_debug_ctrl_if.master dbg
);
    // Index runs 0..NB_REGS; the value NB_REGS selects the cycle-count word
    localparam int               NB_IDX   = $clog2(NB_REGS + 1);
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(NB_REGS);

    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_DUMP = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        DONE,
        DUMP_RD,
        DUMP_TX
    } state_t;

    state_t              state, state_nx;
    logic                halt, halt_nx;
    logic                done, done_nx;
    logic                ret_done, ret_done_nx;
    logic                dump_valid, dump_valid_nx;
    logic                dump_last, dump_last_nx;
    logic [NB_DATA-1:0]  dump_data, dump_data_nx;
    logic [NB_ADDR-1:0]  rf_addr, rf_addr_nx;
    logic [NB_IDX-1:0]   index, index_nx;
    logic [NB_CYCLE-1:0] cycle_count, cycle_count_nx;
    logic                cmd_ready;
    logic                accept;

    assign cmd_ready = (state == IDLE) || (state == DONE);
    assign accept    = dbg.i_cmd_valid && cmd_ready;

    // Next-state and next-output logic for the sequencer and dump datapath
    always_comb begin
        state_nx       = state;
        halt_nx        = halt;
        done_nx        = done;
        ret_done_nx    = ret_done;
        dump_valid_nx  = dump_valid;
        dump_last_nx   = dump_last;
        dump_data_nx   = dump_data;
        index_nx       = index;
        cycle_count_nx = cycle_count;

        if (!halt && (cycle_count != '1)) begin
            cycle_count_nx = cycle_count + 1'b1;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    case (dbg.i_cmd)
                        CMD_RUN: begin
                            state_nx = RUN;
                            halt_nx  = 1'b0;
                        end
                        CMD_STEP: begin
                            state_nx = STEP;
                            halt_nx  = 1'b0;
                        end
                        CMD_DUMP: begin
                            state_nx    = DUMP_RD;
                            ret_done_nx = 1'b0;
                        end
                        default: state_nx = IDLE;
                    endcase
                end
            end
            RUN: begin
                if (dbg.i_stop) begin
                    state_nx = DONE;
                    halt_nx  = 1'b1;
                    done_nx  = 1'b1;
                end
            end
            STEP: begin
                halt_nx = 1'b1;
                if (dbg.i_stop) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            DONE: begin
                if (accept && (dbg.i_cmd == CMD_DUMP)) begin
                    state_nx    = DUMP_RD;
                    ret_done_nx = 1'b1;
                end
            end
            DUMP_RD: begin
                state_nx      = DUMP_TX;
                dump_valid_nx = 1'b1;
                if (index == LAST_IDX) begin
                    dump_data_nx = NB_DATA'(cycle_count);
                    dump_last_nx = 1'b1;
                end else begin
                    dump_data_nx = dbg.i_rf_dbg_data;
                    dump_last_nx = 1'b0;
                end
            end
            DUMP_TX: begin
                if (dbg.i_dump_ready) begin
                    dump_valid_nx = 1'b0;
                    if (dump_last) begin
                        index_nx     = '0;
                        dump_last_nx = 1'b0;
                        state_nx     = ret_done ? DONE : IDLE;
                    end else begin
                        index_nx = index + 1'b1;
                        state_nx = DUMP_RD;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        rf_addr_nx = NB_ADDR'(index_nx);
    end

    // FSM state register
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Registered outputs, dump index and cycle counter
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            halt        <= 1'b1;
            done        <= 1'b0;
            ret_done    <= 1'b0;
            dump_valid  <= 1'b0;
            dump_last   <= 1'b0;
            dump_data   <= '0;
            rf_addr     <= '0;
            index       <= '0;
            cycle_count <= '0;
        end else begin
            halt        <= halt_nx;
            done        <= done_nx;
            ret_done    <= ret_done_nx;
            dump_valid  <= dump_valid_nx;
            dump_last   <= dump_last_nx;
            dump_data   <= dump_data_nx;
            rf_addr     <= rf_addr_nx;
            index       <= index_nx;
            cycle_count <= cycle_count_nx;
        end
    end

    assign dbg.o_cmd_ready   = cmd_ready;
    assign dbg.o_halt        = halt;
    assign dbg.o_done        = done;
    assign dbg.o_rf_dbg_addr = rf_addr;
    assign dbg.o_dump_valid  = dump_valid;
    assign dbg.o_dump_data   = dump_data;
    assign dbg.o_dump_last   = dump_last;
    assign dbg.o_cycle_count = cycle_count;
endmodule

// File: doc/pipeline_debug_ctrl.md
Name: pipeline_debug_ctrl

Overview:
Sequences the MIPS pipeline for the debug path: run-to-halt, single-step, and a register-file dump. It drives the global pipeline halt (the i_halt input of every stage register) and watches o_stop from instruction decode. It borrows the register file's debug read port to stream all registers, followed by the cycle count, over a valid/ready link to the UART framer.

Parameters:
NB_DATA, 32, data word width
NB_ADDR, 5, register file address width
NB_REGS, 32, number of registers dumped (≤ 2**NB_ADDR)
NB_CYCLE, 32, cycle counter width (≤ NB_DATA)

Ports:
clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-high
i_cmd_valid  in  1  command strobe
i_cmd  in  2  command: 00 NOP, 01 RUN, 10 STEP, 11 DUMP
o_cmd_ready  out  1  command accepted when high with i_cmd_valid
i_stop  in  1  HALT instruction present in decode
o_halt  out  1  freezes all pipeline stage registers
o_done  out  1  program has reached HALT
o_rf_dbg_addr  out  NB_ADDR  register file debug read address
i_rf_dbg_data  in  NB_DATA  combinational read data for o_rf_dbg_addr
o_dump_valid  out  1  dump word valid
o_dump_data  out  NB_DATA  dump word
o_dump_last  out  1  final dump word (the cycle count)
i_dump_ready  in  1  consumer ready
o_cycle_count  out  NB_CYCLE  cycles with o_halt low since reset

Behaviour:
- Reset (async, i_rst=1): state IDLE, o_halt=1, o_done=0, o_dump_valid=0, o_dump_last=0, o_dump_data=0, o_rf_dbg_addr=0, o_cycle_count=0, index=0. All outputs are registered except o_cmd_ready.
- o_cmd_ready = 1 only in IDLE and DONE. Accept = i_cmd_valid & o_cmd_ready.
- IDLE: RUN → RUN, STEP → STEP, DUMP → DUMP_RD (return target IDLE), NOP → stay.
- RUN: o_halt=0 from the cycle after accept. i_stop=1 sampled → o_halt=1 and o_done=1 on the next edge, state DONE. No command is accepted in RUN.
- STEP: o_halt=0 for exactly one cycle. Next state is IDLE, or DONE (o_done=1) if i_stop=1 in that cycle.
- DONE: o_halt=1 permanently. DUMP → DUMP_RD (return target DONE). RUN and STEP are accepted and dropped with no effect. Only reset leaves DONE.
- o_cycle_count increments on every edge where o_halt=0 and saturates at all-ones.
- DUMP_RD: o_rf_dbg_addr=index. At the edge, o_dump_data←i_rf_dbg_data, o_dump_valid←1, state DUMP_TX.
- After index reaches NB_REGS, DUMP_RD loads o_dump_data←zero-extended o_cycle_count and o_dump_last←1.
- DUMP_TX: o_dump_data, o_dump_last and o_dump_valid are held stable until i_dump_ready=1.
- On handshake: o_dump_valid←0. If the word was not last: index++ and go to DUMP_RD. If last: index←0, o_dump_last←0, return to the target state.
- Word count per dump is NB_REGS+1. Minimum is 2 cycles per word.
- o_halt stays 1 throughout the dump, and o_cycle_count is frozen.
- i_stop is ignored outside RUN and STEP.
- i_rst asserted mid-dump or mid-run aborts immediately to reset values. No partial word remains valid.

Test Plan:
- Reset, then RUN with i_stop raised 10 cycles after accept → o_halt low exactly 10 cycles, o_done=1, o_cycle_count=10, o_cmd_ready=1.
- Three STEP commands, i_stop=0 → three single-cycle o_halt=0 pulses, o_cycle_count=3, state IDLE after each.
- DUMP with i_rf_dbg_data=addr*4 and i_dump_ready=1 → 33 words 0,4,…,124, then cycle count; o_dump_last only on word 33; returns IDLE.
- DUMP with i_dump_ready toggling 1-of-3 → data and valid stable while stalled, no word lost or repeated, addresses monotone 0..31.
- In DONE, issue RUN → accepted, o_halt stays 1, o_cycle_count unchanged; then DUMP → full dump, returns DONE with o_done=1.
- Assert i_rst during word 5 of a dump → o_dump_valid=0, o_halt=1, o_cycle_count=0 in the same cycle; a new DUMP restarts at address 0.
